radix_div: RTL and testbench

//  Parametrised multi-cycle integer divider for the ZipCPU DIV/DIVS unit.

---
 rtl/radix_div_pkg.sv | 24 ++
 rtl/radix_div_step.sv | 40 ++++
 rtl/radix_div.sv | 153 +++++++++++++++
 tb/tb_radix_div.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/radix_div_pkg.sv
// Shared definitions for the radix_div divider: state encoding,
// condition-flag bit positions and the parameter legality check.
package radix_div_pkg;

    // FSM encoding, kept as plain constants for older tool flows
    localparam int          STATE_W    = 2;
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_PRESIGN = 2'd1;
    localparam logic [1:0]  ST_ITER    = 2'd2;
    localparam logic [1:0]  ST_POST    = 2'd3;

    // Bit positions inside o_flags = {V,N,C,Z}
    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    // Quotient bits per cycle must be 1, 2 or 4 and evenly divide the width
    function automatic logic bpc_ok(input int bw, input int bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4)) &&
               (bw >= 8) && ((bw % bpc) == 0);
    endfunction

endpackage

// File: rtl/radix_div_step.sv
// Combinational restoring-division step retiring BPC quotient bits.
// The partial remainder is always kept below the divisor, so its top
// bit is only needed transiently while a new dividend bit is shifted in.
module radix_div_step
    import radix_div_pkg::*;
#(
    parameter int BW  = 32,
    parameter int BPC = 1
) (
    input  logic [BW:0]    i_rem,
    input  logic [BW-1:0]  i_den,
    input  logic [BPC-1:0] i_bits,
    output logic [BW:0]    o_rem,
    output logic [BPC-1:0] o_q
);

    logic [BW:0]   r;
    logic [BW:0]   shifted;
    logic [BW+1:0] diff;

    // BPC chained shift/trial-subtract/restore stages, MSB first
    always_comb begin
        r       = i_rem;
        shifted = '0;
        diff    = '0;
        o_q     = '0;
        for (int i = BPC - 1; i >= 0; i--) begin
            shifted = {r[BW-1:0], i_bits[i]};
            diff    = {1'b0, shifted} - {2'b00, i_den};
            if (!diff[BW+1]) begin
                r      = diff[BW:0];
                o_q[i] = 1'b1;
            end else begin
                r = shifted;
            end
        end
        o_rem = r;
    end

endmodule

// File: rtl/radix_div.sv
// Multi-cycle signed/unsigned restoring divider with remainder,
// divide-by-zero error and synchronous flush.
// Handshake: i_wr is accepted only in a cycle where o_busy is low; o_busy
// then stays high until the cycle in which o_valid strobes for exactly one
// cycle with the result. o_busy and o_valid are never high together.
module radix_div
    import radix_div_pkg::*;
#(
    parameter int   BW           = 32,
    parameter int   BPC          = 1,
    parameter logic OPT_LOWPOWER = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_clear,
    input  logic               i_wr,
    input  logic               i_signed,
    input  logic [BW-1:0]      i_numerator,
    input  logic [BW-1:0]      i_denominator,
    output logic               o_busy,
    output logic               o_valid,
    output logic               o_err,
    output logic [BW-1:0]      o_quotient,
    output logic [BW-1:0]      o_remainder,
    output logic [3:0]         o_flags,
    output logic [STATE_W-1:0] o_state
);

    if (!bpc_ok(BW, BPC)) begin : g_bad_params
        $error("radix_div: BPC must be 1, 2 or 4, divide BW, and BW >= 8");
    end

    localparam int             CNT_W    = $clog2(BW / BPC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BW / BPC - 1);

    logic [STATE_W-1:0] state;
    logic [BW:0]        rem;       // partial remainder
    logic [BW-1:0]      quo;       // dividend bits out at top, quotient bits in at bottom
    logic [BW-1:0]      den;
    logic [CNT_W-1:0]   cnt;
    logic               sgn, q_neg, r_neg, den_zero;
    logic               valid_r, err_r;
    logic [BW-1:0]      q_r, r_r;
    logic [BW:0]        step_rem;
    logic [BPC-1:0]     step_q;
    logic [BW-1:0]      next_quo;
    logic [3:0]         flags_r;

    radix_div_step #(.BW(BW), .BPC(BPC)) u_step (
        .i_rem  (rem),
        .i_den  (den),
        .i_bits (quo[BW-1 -: BPC]),
        .o_rem  (step_rem),
        .o_q    (step_q)
    );

    assign next_quo = {quo[BW-BPC-1:0], step_q};

    // Divider FSM: accept, fix signs, iterate, fix result signs, strobe
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            rem      <= '0;
            quo      <= '0;
            den      <= '0;
            cnt      <= '0;
            sgn      <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            den_zero <= 1'b0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            q_r      <= '0;
            r_r      <= '0;
        end else if (i_clear) begin
            state   <= ST_IDLE;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_wr) begin
                        quo      <= i_numerator;
                        den      <= i_denominator;
                        rem      <= '0;
                        cnt      <= CNT_LOAD;
                        sgn      <= i_signed;
                        den_zero <= (i_denominator == '0);
                        q_neg    <= i_signed & (i_numerator[BW-1] ^ i_denominator[BW-1]);
                        r_neg    <= i_signed & i_numerator[BW-1];
                        // A zero divisor goes straight to the one-cycle result stage
                        if (i_denominator == '0)
                            state <= ST_POST;
                        else if (i_signed)
                            state <= ST_PRESIGN;
                        else
                            state <= ST_ITER;
                    end
                end
                ST_PRESIGN: begin
                    if (quo[BW-1]) quo <= -quo;
                    if (den[BW-1]) den <= -den;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    rem <= step_rem;
                    quo <= next_quo;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        if (sgn) begin
                            state <= ST_POST;
                        end else begin
                            state   <= ST_IDLE;
                            valid_r <= 1'b1;
                            q_r     <= next_quo;
                            r_r     <= step_rem[BW-1:0];
                        end
                    end
                end
                default: begin // ST_POST
                    state   <= ST_IDLE;
                    valid_r <= 1'b1;
                    err_r   <= den_zero;
                    if (den_zero) begin
                        q_r <= '0;
                        r_r <= '0;
                    end else begin
                        q_r <= q_neg ? -quo : quo;
                        r_r <= r_neg ? -rem[BW-1:0] : rem[BW-1:0];
                    end
                end
            endcase
        end
    end

    // Condition flags derived from the held quotient
    always_comb begin
        flags_r         = '0;
        flags_r[FLAG_N] = q_r[BW-1];
        flags_r[FLAG_Z] = (q_r == '0);
    end

    assign o_busy      = (state != ST_IDLE);
    assign o_valid     = valid_r;
    assign o_err       = err_r;
    assign o_state     = state;
    assign o_quotient  = (OPT_LOWPOWER && !valid_r) ? '0 : q_r;
    assign o_remainder = (OPT_LOWPOWER && !valid_r) ? '0 : r_r;
    assign o_flags     = (OPT_LOWPOWER && !valid_r) ? 4'b0000 : flags_r;

endmodule

// File: tb/tb_radix_div.sv
// Directed bench for radix_div: dut_a is BW=32/BPC=1, dut_b is BW=32/BPC=4.
// Both share the stimulus; use_b selects which one is observed.
module tb_radix_div;
    import radix_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, clr, wr, sgn;
    logic [31:0] num, den;

    logic        busy_a, valid_a, err_a, busy_b, valid_b, err_b;
    logic [31:0] q_a, r_a, q_b, r_b;
    logic [3:0]  f_a, f_b;
    logic [1:0]  st_a, st_b;

    logic        use_b = 1'b0;
    logic        busy, valid, err;
    logic [31:0] q, r;
    logic [3:0]  f;
    logic [1:0]  st;

    int errors = 0;
    int checks = 0;
    int vcyc, bcnt, vcnt;
    logic [1:0] st1;

    assign busy  = use_b ? busy_b  : busy_a;
    assign valid = use_b ? valid_b : valid_a;
    assign err   = use_b ? err_b   : err_a;
    assign q     = use_b ? q_b     : q_a;
    assign r     = use_b ? r_b     : r_a;
    assign f     = use_b ? f_b     : f_a;
    assign st    = use_b ? st_b    : st_a;

    // clock
    always #5 clk = ~clk;

    radix_div #(.BW(32), .BPC(1)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .i_wr(wr), .i_signed(sgn),
        .i_numerator(num), .i_denominator(den),
        .o_busy(busy_a), .o_valid(valid_a), .o_err(err_a),
        .o_quotient(q_a), .o_remainder(r_a), .o_flags(f_a), .o_state(st_a)
    );

    radix_div #(.BW(32), .BPC(4)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .i_wr(wr), .i_signed(sgn),
        .i_numerator(num), .i_denominator(den),
        .o_busy(busy_b), .o_valid(valid_b), .o_err(err_b),
        .o_quotient(q_b), .o_remainder(r_b), .o_flags(f_b), .o_state(st_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue an operation in the current cycle (cycle 0) and step until o_valid
    // or a 60-cycle budget runs out. Returns the strobe cycle (-1 if none),
    // the number of busy cycles and the state seen in cycle 1. A non-zero
    // inj pulses a stray i_wr with different operands in that cycle.
    task automatic run_op(input logic [31:0] n, input logic [31:0] d, input logic s,
                          input int inj, output int vc, output int bc, output logic [1:0] s1);
        num = n; den = d; sgn = s; wr = 1'b1;
        tick();
        wr = 1'b0;
        vc = -1; bc = 0; s1 = st;
        for (int c = 1; c <= 60; c++) begin
            wr = 1'b0;
            if (valid) begin
                vc = c;
                chk("busy_with_valid", {63'd0, busy}, 64'd0);
                break;
            end
            if (busy) bc++;
            if (c == inj) begin
                num = 32'd999; den = 32'd3; sgn = 1'b0; wr = 1'b1;
            end
            tick();
        end
        wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr = 1'b0; sgn = 1'b0; num = '0; den = '0;

        // reset state
        tick(); tick();
        chk("rst_busy",  {63'd0, busy},  64'd0);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_err",   {63'd0, err},   64'd0);
        chk("rst_q",     {32'd0, q},     64'd0);
        chk("rst_r",     {32'd0, r},     64'd0);
        chk("rst_flags", {60'd0, f},     64'h1);
        chk("rst_state", {62'd0, st},    {62'd0, ST_IDLE});
        rst_n = 1'b1;
        tick(); tick();

        // unsigned 100/7
        run_op(32'd100, 32'd7, 1'b0, 0, vcyc, bcnt, st1);
        chk("u100_7_vcyc", 64'(vcyc), 64'd33);
        chk("u100_7_busy", 64'(bcnt), 64'd32);
        chk("u100_7_st1",  {62'd0, st1}, {62'd0, ST_ITER});
        chk("u100_7_q",    {32'd0, q}, 64'd14);
        chk("u100_7_r",    {32'd0, r}, 64'd2);
        chk("u100_7_f",    {60'd0, f}, 64'h0);
        chk("u100_7_err",  {63'd0, err}, 64'd0);
        tick();
        chk("u100_7_strobe_len", {63'd0, valid}, 64'd0);
        chk("u100_7_q_hold",     {32'd0, q},     64'd14);
        tick();

        // signed -100/7
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0, vcyc, bcnt, st1);
        chk("s_m100_7_vcyc", 64'(vcyc), 64'd35);
        chk("s_m100_7_busy", 64'(bcnt), 64'd34);
        chk("s_m100_7_st1",  {62'd0, st1}, {62'd0, ST_PRESIGN});
        chk("s_m100_7_q",    {32'd0, q}, 64'hFFFF_FFF2);
        chk("s_m100_7_r",    {32'd0, r}, 64'hFFFF_FFFE);
        chk("s_m100_7_f",    {60'd0, f}, 64'h4);
        tick();

        // signed 100/-7: remainder keeps numerator sign
        run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 0, vcyc, bcnt, st1);
        chk("s_100_m7_q", {32'd0, q}, 64'hFFFF_FFF2);
        chk("s_100_m7_r", {32'd0, r}, 64'd2);
        tick();

        // 5/0
        run_op(32'd5, 32'd0, 1'b0, 0, vcyc, bcnt, st1);
        chk("div0_vcyc", 64'(vcyc), 64'd2);
        chk("div0_busy", 64'(bcnt), 64'd1);
        chk("div0_err",  {63'd0, err}, 64'd1);
        chk("div0_q",    {32'd0, q}, 64'd0);
        chk("div0_r",    {32'd0, r}, 64'd0);
        tick();
        chk("div0_err_clears", {63'd0, err}, 64'd0);

        // signed MIN/-1 wraps without error
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, vcyc, bcnt, st1);
        chk("min_m1_vcyc", 64'(vcyc), 64'd35);
        chk("min_m1_q",    {32'd0, q}, 64'h8000_0000);
        chk("min_m1_r",    {32'd0, r}, 64'd0);
        chk("min_m1_f",    {60'd0, f}, 64'h4);
        chk("min_m1_err",  {63'd0, err}, 64'd0);
        tick();

        // unsigned large operands
        run_op(32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 0, vcyc, bcnt, st1);
        chk("big_q", {32'd0, q}, 64'h0000_FFFF);
        chk("big_r", {32'd0, r}, 64'h0000_FFFF);
        tick();

        // zero quotient sets Z
        run_op(32'd3, 32'd7, 1'b0, 0, vcyc, bcnt, st1);
        chk("zero_q", {32'd0, q}, 64'd0);
        chk("zero_r", {32'd0, r}, 64'd3);
        chk("zero_f", {60'd0, f}, 64'h1);
        tick();

        // stray i_wr while busy is ignored
        run_op(32'd100, 32'd7, 1'b0, 5, vcyc, bcnt, st1);
        chk("wr_busy_vcyc", 64'(vcyc), 64'd33);
        chk("wr_busy_q",    {32'd0, q}, 64'd14);
        tick(); tick();

        // i_clear at cycle 10 of 100/7, then restart at cycle 12
        num = 32'd100; den = 32'd7; sgn = 1'b0; wr = 1'b1;
        tick();
        wr = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_busy_c11",  {63'd0, busy},  64'd0);
        chk("clr_valid_c11", {63'd0, valid}, 64'd0);
        tick();
        chk("clr_valid_c12", {63'd0, valid}, 64'd0);
        run_op(32'd100, 32'd7, 1'b0, 0, vcyc, bcnt, st1);
        chk("clr_restart_vcyc", 64'(vcyc), 64'd33);
        chk("clr_restart_q",    {32'd0, q}, 64'd14);
        tick(); tick();

        // BPC=4 instance
        use_b = 1'b1;
        #1;
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, vcyc, bcnt, st1);
        chk("b4_vcyc", 64'(vcyc), 64'd9);
        chk("b4_busy", 64'(bcnt), 64'd8);
        chk("b4_q",    {32'd0, q}, 64'hFFFF_FFFF);
        chk("b4_r",    {32'd0, r}, 64'd0);
        chk("b4_f",    {60'd0, f}, 64'h4);
        tick();

        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0, vcyc, bcnt, st1);
        chk("b4_s_vcyc", 64'(vcyc), 64'd11);
        chk("b4_s_q",    {32'd0, q}, 64'hFFFF_FFF2);
        chk("b4_s_r",    {32'd0, r}, 64'hFFFF_FFFE);
        tick();

        // async reset at cycle 4 of a BPC=4 divide
        num = 32'd1000; den = 32'd3; sgn = 1'b0; wr = 1'b1;
        tick();
        wr = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  {63'd0, busy},  64'd0);
        chk("arst_valid", {63'd0, valid}, 64'd0);
        chk("arst_q",     {32'd0, q},     64'd0);
        chk("arst_r",     {32'd0, r},     64'd0);
        chk("arst_state", {62'd0, st},    {62'd0, ST_IDLE});
        tick();
        rst_n = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (valid || busy) vcnt++;
        end
        chk("arst_no_strobe", 64'(vcnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
